// File: rtl/timer_pkg.sv
// timer_pkg: definitions shared by the two-mode timer blocks.
//   state_e        - run/alarm state machine encoding
//   MODE_STOPWATCH - display mux select value for the up counter (mux in1)
//   MODE_COUNTDOWN - display mux select value for the down counter (mux in2)
package timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StAlarm
    } state_e;

    // The display mux select encoding lives here only.
    localparam logic MODE_STOPWATCH = 1'b0;
    localparam logic MODE_COUNTDOWN = 1'b1;

endpackage : timer_pkg

// File: rtl/edge_detect.sv
// edge_detect: rising-edge detector for one debounced button level.
//   clk    - system clock
//   reset  - synchronous active-high reset
//   level  - debounced button level
//   press  - single-cycle pulse, high while level is 1 and was 0 last cycle
// The history flop resets to 1 so a button held through reset is not a press.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic press
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level;
        press  = level & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule : edge_detect

// File: rtl/timer_mode_ctrl.sv
// timer_mode_ctrl: mode/run controller for the two-mode timer.
// Holds the stopwatch (up) and countdown (down) counters and the
// IDLE/RUN/PAUSE/ALARM state machine, and drives the display mux select.
//   clk        - system clock
//   reset      - synchronous active-high reset
//   tick       - single-cycle 1 Hz count enable
//   btn_mode   - debounced level, rising edge toggles mode (IDLE only)
//   btn_start  - debounced level, rising edge is start/pause/acknowledge
//   btn_clear  - debounced level, rising edge clears
//   preset     - countdown load value, clamped to MAX_COUNT when loaded
//   sel        - display mux select (MODE_STOPWATCH / MODE_COUNTDOWN)
//   up_count   - stopwatch value
//   down_count - countdown value
//   running    - high in RUN
//   alarm      - high in ALARM
// All outputs are registered.
module timer_mode_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned MAX_COUNT      = 99,
    parameter int unsigned PRESET_DEFAULT = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             btn_mode,
    input  logic             btn_start,
    input  logic             btn_clear,
    input  logic [WIDTH-1:0] preset,
    output logic             sel,
    output logic [WIDTH-1:0] up_count,
    output logic [WIDTH-1:0] down_count,
    output logic             running,
    output logic             alarm
);

    localparam logic [WIDTH-1:0] MaxCnt     = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] PresetRst  = WIDTH'(PRESET_DEFAULT);
    localparam logic [WIDTH-1:0] One        = WIDTH'(1);
    localparam logic [WIDTH-1:0] Zero       = '0;

    function automatic logic [WIDTH-1:0] clamp_preset(input logic [WIDTH-1:0] p);
        return (p > MaxCnt) ? MaxCnt : p;
    endfunction

    logic press_mode;
    logic press_start;
    logic press_clear;

    edge_detect u_edge_mode (
        .clk   (clk),
        .reset (reset),
        .level (btn_mode),
        .press (press_mode)
    );

    edge_detect u_edge_start (
        .clk   (clk),
        .reset (reset),
        .level (btn_start),
        .press (press_start)
    );

    edge_detect u_edge_clear (
        .clk   (clk),
        .reset (reset),
        .level (btn_clear),
        .press (press_clear)
    );

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] up_q, up_d;
    logic [WIDTH-1:0] down_q, down_d;
    logic             running_q, running_d;
    logic             alarm_q, alarm_d;

    logic count_en;
    logic start_blocked;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        up_d    = up_q;
        down_d  = down_q;

        // Ticks count only if RUN at the start of the cycle, so a start press
        // that pauses in this cycle still lets this tick through.
        count_en      = (state_q == StRun) && tick;
        // Countdown with nothing left to count cannot be started.
        start_blocked = (sel_q == MODE_COUNTDOWN) && (down_q == Zero);

        if (press_clear) begin
            state_d = StIdle;
            up_d    = Zero;
            down_d  = clamp_preset(preset);
        end else begin
            if (count_en) begin
                if (sel_q == MODE_STOPWATCH) begin
                    up_d = (up_q == MaxCnt) ? Zero : up_q + One;
                end else if (down_q != Zero) begin
                    down_d = down_q - One;
                    if (down_q == One) begin
                        state_d = StAlarm;
                    end
                end
            end

            // Start outranks the tick's state change and suppresses mode.
            if (press_start) begin
                unique case (state_q)
                    StIdle, StPause: begin
                        if (!start_blocked) begin
                            state_d = StRun;
                        end
                    end
                    StRun: begin
                        state_d = StPause;
                    end
                    StAlarm: begin
                        state_d = StIdle;
                        down_d  = clamp_preset(preset);
                    end
                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end else if (press_mode && (state_q == StIdle)) begin
                sel_d = ~sel_q;
            end
        end

        running_d = (state_d == StRun);
        alarm_d   = (state_d == StAlarm);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            sel_q     <= MODE_STOPWATCH;
            up_q      <= Zero;
            down_q    <= PresetRst;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            up_q      <= up_d;
            down_q    <= down_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

    assign sel        = sel_q;
    assign up_count   = up_q;
    assign down_count = down_q;
    assign running    = running_q;
    assign alarm      = alarm_q;

endmodule : timer_mode_ctrl

// File: tb/tb_timer_mode_ctrl.sv
// Self-checking bench for timer_mode_ctrl: a directed vector table followed by
// randomized stimulus compared against a behavioural model.
module tb_timer_mode_ctrl;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       btn_mode;
    logic       btn_start;
    logic       btn_clear;
    logic [7:0] preset;
    logic       sel;
    logic [7:0] up_count;
    logic [7:0] down_count;
    logic       running;
    logic       alarm;

    int n_checks = 0;
    int n_fail   = 0;

    timer_mode_ctrl #(
        .WIDTH          (8),
        .MAX_COUNT      (99),
        .PRESET_DEFAULT (30)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .btn_mode   (btn_mode),
        .btn_start  (btn_start),
        .btn_clear  (btn_clear),
        .preset     (preset),
        .sel        (sel),
        .up_count   (up_count),
        .down_count (down_count),
        .running    (running),
        .alarm      (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus plus the outputs expected after that edge.
    typedef struct {
        logic       rst;
        logic       m;
        logic       s;
        logic       c;
        logic       t;
        int         p;
        int         e_sel;
        int         e_up;
        int         e_down;
        int         e_run;
        int         e_alarm;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic m, input logic s, input logic c,
                                input logic t, input int p, input int es, input int eu,
                                input int ed, input int er, input int ea);
        vec_t v;
        v.rst = rst; v.m = m; v.s = s; v.c = c; v.t = t; v.p = p;
        v.e_sel = es; v.e_up = eu; v.e_down = ed; v.e_run = er; v.e_alarm = ea;
        vecs.push_back(v);
    endfunction

    // Behavioural model: plain integers, rules applied in priority order.
    localparam int MIdle = 0, MRun = 1, MPause = 2, MAlarm = 3;
    int m_state, m_sel, m_up, m_down;
    int m_prev_m, m_prev_s, m_prev_c;

    function automatic void model_step(input int rst, input int m, input int s, input int c,
                                       input int t, input int p);
        int nxt;
        int ld;
        bit pm, ps, pc;
        ld = (p > 99) ? 99 : p;
        if (rst != 0) begin
            m_state = MIdle; m_sel = 0; m_up = 0; m_down = 30;
            m_prev_m = 1; m_prev_s = 1; m_prev_c = 1;
            return;
        end
        pm = (m != 0) && (m_prev_m == 0);
        ps = (s != 0) && (m_prev_s == 0);
        pc = (c != 0) && (m_prev_c == 0);
        m_prev_m = m; m_prev_s = s; m_prev_c = c;
        if (pc) begin
            m_state = MIdle; m_up = 0; m_down = ld;
            return;
        end
        nxt = m_state;
        if (m_state == MRun && t != 0) begin
            if (m_sel == 0) begin
                m_up = (m_up + 1) % 100;
            end else if (m_down > 0) begin
                m_down = m_down - 1;
                if (m_down == 0) nxt = MAlarm;
            end
        end
        if (ps) begin
            if (m_state == MRun) nxt = MPause;
            else if (m_state == MAlarm) begin
                nxt = MIdle;
                m_down = ld;
            end else if (!(m_sel == 1 && m_down == 0)) nxt = MRun;
        end else if (pm && m_state == MIdle) begin
            m_sel = 1 - m_sel;
        end
        m_state = nxt;
    endfunction

    task automatic check(input string name, input int es, input int eu, input int ed,
                         input int er, input int ea);
        n_checks++;
        if (int'(sel) != es || int'(up_count) != eu || int'(down_count) != ed ||
            int'(running) != er || int'(alarm) != ea) begin
            n_fail++;
            $display("FAIL %s @%0t: got sel=%0d up=%0d down=%0d run=%0d alarm=%0d, expected sel=%0d up=%0d down=%0d run=%0d alarm=%0d",
                     name, $time, sel, up_count, down_count, running, alarm,
                     es, eu, ed, er, ea);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic s, input logic c,
                         input logic t, input int p);
        reset     = r;
        btn_mode  = m;
        btn_start = s;
        btn_clear = c;
        tick      = t;
        preset    = 8'(p);
        model_step(int'(r), int'(m), int'(s), int'(c), int'(t), p);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_start = 1'b0;
        btn_clear = 1'b0; preset = 8'd0;

        // Reset with start held, then 3 ticks in IDLE: nothing happens.
        add(1, 0, 1, 0, 0, 0,  0, 0, 30, 0, 0);
        add(1, 0, 1, 0, 0, 0,  0, 0, 30, 0, 0);
        add(0, 0, 1, 0, 1, 0,  0, 0, 30, 0, 0);
        add(0, 0, 0, 0, 1, 0,  0, 0, 30, 0, 0);
        add(0, 0, 0, 0, 1, 0,  0, 0, 30, 0, 0);
        // Stopwatch: start, 100 ticks through the wrap.
        add(0, 0, 1, 0, 0, 0,  0, 0, 30, 1, 0);
        for (int i = 1; i <= 100; i++) add(0, 0, 1, 0, 1, 0,  0, i % 100, 30, 1, 0);
        add(0, 0, 0, 0, 1, 0,  0, 1, 30, 1, 0);
        // Start+tick while RUN: tick counted, then PAUSE holds.
        add(0, 0, 1, 0, 1, 0,  0, 2, 30, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0,  0, 2, 30, 0, 0);
        // Mode ignored in PAUSE.
        add(0, 1, 0, 0, 0, 0,  0, 2, 30, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 2, 30, 0, 0);
        // Countdown from preset 3 into ALARM.
        add(0, 0, 0, 1, 0, 3,  0, 0, 3, 0, 0);
        add(0, 0, 0, 0, 0, 3,  0, 0, 3, 0, 0);
        add(0, 1, 0, 0, 0, 3,  1, 0, 3, 0, 0);
        add(0, 0, 0, 0, 0, 3,  1, 0, 3, 0, 0);
        add(0, 0, 1, 0, 0, 3,  1, 0, 3, 1, 0);
        add(0, 0, 0, 0, 1, 3,  1, 0, 2, 1, 0);
        add(0, 0, 0, 0, 1, 3,  1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 3,  1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 3,  1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 3,  1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 3,  1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 1);
        // Acknowledge reloads the preset.
        add(0, 0, 1, 0, 0, 3,  1, 0, 3, 0, 0);
        // Preset above MAX_COUNT clamps on clear.
        add(0, 0, 0, 0, 0, 200,  1, 0, 3, 0, 0);
        add(0, 0, 0, 1, 0, 200,  1, 0, 99, 0, 0);
        add(0, 0, 0, 0, 0, 200,  1, 0, 99, 0, 0);
        add(0, 0, 1, 0, 0, 200,  1, 0, 99, 1, 0);
        add(0, 0, 0, 0, 1, 200,  1, 0, 98, 1, 0);
        // Clear beats start and tick.
        add(0, 0, 1, 1, 1, 5,  1, 0, 5, 0, 0);
        add(0, 0, 0, 0, 0, 5,  1, 0, 5, 0, 0);
        add(0, 0, 1, 0, 0, 5,  1, 0, 5, 1, 0);
        // Mode ignored in RUN.
        add(0, 1, 1, 0, 0, 5,  1, 0, 5, 1, 0);
        add(0, 0, 0, 0, 0, 5,  1, 0, 5, 1, 0);
        // Countdown at 0 cannot be started.
        add(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        // Stopwatch to 42, then reset mid-RUN.
        add(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0);
        for (int i = 1; i <= 42; i++) add(0, 0, 0, 0, 1, 0,  0, i, 0, 1, 0);
        add(1, 1, 1, 1, 1, 7,  0, 0, 30, 0, 0);
        add(0, 0, 0, 0, 0, 7,  0, 0, 30, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].m, vecs[i].s, vecs[i].c, vecs[i].t, vecs[i].p);
            check($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_up, vecs[i].e_down,
                  vecs[i].e_run, vecs[i].e_alarm);
        end

        // Randomized phase against the model, which is in step with the DUT here.
        begin
            logic lm, ls, lc;
            int   p;
            lm = 1'b0; ls = 1'b0; lc = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 7) == 0)  lm = ~lm;
                if ($urandom_range(0, 3) == 0)  ls = ~ls;
                if ($urandom_range(0, 15) == 0) lc = ~lc;
                p = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 10));
                drive(($urandom_range(0, 299) == 0), lm, ls, lc,
                      logic'($urandom_range(0, 1)), p);
                check("random", m_sel, m_up, m_down, int'(m_state == MRun),
                      int'(m_state == MAlarm));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_timer_mode_ctrl

// File: doc/timer_mode_ctrl.md
Name: timer_mode_ctrl

Overview:
Mode and run controller for the two-mode timer. It holds the stopwatch (up) and countdown (down) counters and runs the start/pause/alarm state machine. It drives the select line of the 8-bit 2-way display mux: mux input 1 is up_count and mux input 2 is down_count. It sits between the debounced front-panel buttons, the 1 Hz tick generator and the display path.

Parameters:
WIDTH, 8, counter and preset width; must match the display mux width.
MAX_COUNT, 99, stopwatch wrap point and countdown preset ceiling.
PRESET_DEFAULT, 30, down_count value after reset.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high; one clock, no other clock domains.
tick  input  1  single-cycle 1 Hz count enable.
btn_mode  input  1  debounced level; a rising edge toggles mode.
btn_start  input  1  debounced level; a rising edge means start/pause/acknowledge.
btn_clear  input  1  debounced level; a rising edge clears.
preset  input  WIDTH  countdown load value, sampled on clear and on alarm acknowledge.
sel  output  1  display mux select: 0 = stopwatch (in1), 1 = countdown (in2).
up_count  output  WIDTH  stopwatch value, to mux in1.
down_count  output  WIDTH  countdown value, to mux in2.
running  output  1  high in RUN.
alarm  output  1  high in ALARM.

Behaviour:
- All outputs are registered.
- Reset values: sel=0, up_count=0, down_count=PRESET_DEFAULT, running=0, alarm=0, state=IDLE.
- Button edge-detect registers reset to 1, so a button held through reset does not produce a press.
- press_x = btn_x & ~btn_x_prev.
- An action takes effect at the same clock edge that samples the press; outputs show the result 1 cycle after the button rises.
- States: IDLE, RUN, PAUSE, ALARM.
- Priority in any cycle: clear > start > mode > tick.
- Clear, from any state:
  - go to IDLE; up_count=0; down_count=min(preset, MAX_COUNT); alarm=0.
  - sel is unchanged.
  - a tick in the same cycle is discarded.
- Mode press:
  - accepted only in IDLE, where it toggles sel.
  - ignored in RUN, PAUSE and ALARM.
- Start press:
  - IDLE->RUN and PAUSE->RUN.
  - RUN->PAUSE.
  - ALARM->IDLE with down_count reloaded from preset (clamped), alarm=0.
  - In IDLE/PAUSE with sel=1 and down_count==0, start is ignored and the state stays put.
- Tick, counted only when state is RUN at the start of the cycle (a start press that pauses in the same cycle still counts that tick):
  - sel=0: up_count increments; at MAX_COUNT it wraps to 0 and stays in RUN.
  - sel=1: down_count decrements. When down_count==1, it goes to 0, state goes to ALARM and alarm=1 on that same edge.
- ALARM: counters frozen; ticks ignored; mode ignored. Exit only via start or clear.
- Preset values above MAX_COUNT are clamped to MAX_COUNT on load.
- The inactive counter holds its value; switching sel never alters either counter.
- Reset asserted mid-operation returns to reset values on the next edge, regardless of the other inputs.

Decomposition:
- Shared package timer_pkg:
  - state enum (IDLE, RUN, PAUSE, ALARM).
  - constants MODE_STOPWATCH=0 and MODE_COUNTDOWN=1.
  - encode sel with these constants so the mux select encoding is defined once.
- One natural sub-module: edge_detect (1-bit register resetting to 1, rising-edge pulse out), instantiated once per button.
- Counters and FSM stay in timer_mode_ctrl.

Test Plan:
- Reset with btn_start held high, release, 3 ticks -> state IDLE, no press registered, up_count=0, down_count=30, sel=0.
- Stopwatch: start press, 100 ticks -> up_count passes 99 then 0, running=1 throughout; start press -> PAUSE, further ticks leave up_count unchanged.
- Countdown: mode press (sel=1), preset=3, clear, start, 3 ticks -> down_count 2,1,0 and alarm=1 on the 3rd-tick edge; extra ticks do not change 0; start press -> IDLE, down_count=3, alarm=0.
- Priority: clear+start+tick in one cycle while RUN -> IDLE, counters reloaded, no count; start+tick in one cycle while RUN -> count applied, state PAUSE.
- Mode press while RUN or PAUSE -> sel unchanged; preset=200 then clear -> down_count=99; sel=1 with down_count=0 then start -> stays IDLE.
- Reset mid-RUN with up_count=42 -> next edge gives all outputs at reset values.
